// File: rtl/nine_segment_dice_controller.sv
// Electronic die sequencer: free-running scan strobe, seeded roll animation with
// progressively longer dwells, and a registered nine-segment face pattern.
module nine_segment_dice_controller #(
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned ROLL_STEP_BASE = 50000,
  parameter int unsigned ROLL_STEPS     = 12,
  parameter int unsigned MAX_FACE       = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       roll_req,
  input  logic       clear,
  output logic       scan_enable,
  output logic [8:0] segments,
  output logic [2:0] value,
  output logic       busy,
  output logic       done
);

  localparam int unsigned SCAN_W  = $clog2(SCAN_DIV);
  localparam int unsigned STEP_W  = (ROLL_STEPS > 1) ? $clog2(ROLL_STEPS) : 1;
  localparam int unsigned TIMER_W = 32;

  localparam logic [SCAN_W-1:0]  SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [STEP_W-1:0]  STEP_LAST = STEP_W'(ROLL_STEPS - 1);
  localparam logic [TIMER_W-1:0] BASE     = TIMER_W'(ROLL_STEP_BASE);
  localparam logic [2:0]         FACE_MAX = 3'(MAX_FACE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROLLING,
    S_SHOW
  } state_e;

  state_e             state_q, state_d;
  logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
  logic               scan_en_q, scan_en_d;
  logic [2:0]         seed_q, seed_d;
  logic               roll_req_q;
  logic               roll_edge_c;
  logic [2:0]         value_q, value_d;
  logic [8:0]         segments_q, segments_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [TIMER_W-1:0] dwell_q, dwell_d;

  // Pip layout for each face value on the 3x3 grid.
  function automatic logic [8:0] seg_of(input logic [2:0] face);
    logic [8:0] s;
    case (face)
      3'd1:    s = 9'b000010000;
      3'd2:    s = 9'b100000001;
      3'd3:    s = 9'b100010001;
      3'd4:    s = 9'b101000101;
      3'd5:    s = 9'b101010101;
      3'd6:    s = 9'b111000111;
      3'd7:    s = 9'b111010111;
      default: s = 9'b000000000;
    endcase
    return s;
  endfunction

  function automatic logic [2:0] next_face(input logic [2:0] face);
    return (face == FACE_MAX) ? 3'd1 : face + 3'd1;
  endfunction

  assign roll_edge_c = roll_req & ~roll_req_q;

  always_comb begin
    state_d    = state_q;
    value_d    = value_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    step_d     = step_q;
    timer_d    = timer_q;
    dwell_d    = dwell_q;

    // Scan strobe is registered so it lines up with the counter reaching its last value.
    scan_cnt_d = (scan_cnt_q == SCAN_LAST) ? '0 : scan_cnt_q + SCAN_W'(1);
    scan_en_d  = (scan_cnt_d == SCAN_LAST);
    seed_d     = next_face(seed_q);

    if (clear) begin
      state_d = S_IDLE;
      value_d = 3'd0;
      busy_d  = 1'b0;
      step_d  = '0;
      timer_d = '0;
      dwell_d = '0;
    end else begin
      case (state_q)
        S_IDLE, S_SHOW: begin
          if (roll_edge_c) begin
            state_d = S_ROLLING;
            busy_d  = 1'b1;
            value_d = seed_q;
            step_d  = '0;
            timer_d = BASE;
            dwell_d = BASE;
          end
        end
        S_ROLLING: begin
          if (timer_q == TIMER_W'(1)) begin
            if (step_q == STEP_LAST) begin
              state_d = S_SHOW;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              // Each dwell is one base period longer than the last.
              value_d = next_face(value_q);
              step_d  = step_q + STEP_W'(1);
              dwell_d = dwell_q + BASE;
              timer_d = dwell_q + BASE;
            end
          end else begin
            timer_d = timer_q - TIMER_W'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          value_d = 3'd0;
          busy_d  = 1'b0;
        end
      endcase
    end

    segments_d = seg_of(value_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      scan_cnt_q <= '0;
      scan_en_q  <= 1'b0;
      seed_q     <= 3'd1;
      roll_req_q <= 1'b0;
      value_q    <= 3'd0;
      segments_q <= 9'b000000000;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      step_q     <= '0;
      timer_q    <= '0;
      dwell_q    <= '0;
    end else begin
      state_q    <= state_d;
      scan_cnt_q <= scan_cnt_d;
      scan_en_q  <= scan_en_d;
      seed_q     <= seed_d;
      roll_req_q <= roll_req;
      value_q    <= value_d;
      segments_q <= segments_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      step_q     <= step_d;
      timer_q    <= timer_d;
      dwell_q    <= dwell_d;
    end
  end

  assign scan_enable = scan_en_q;
  assign segments    = segments_q;
  assign value       = value_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_nine_segment_dice_controller.sv
// Scoreboard bench for nine_segment_dice_controller: three parameterisations share
// one clock; expected per-cycle outputs are queued by stimulus and checked by a monitor.
module tb_nine_segment_dice_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       req_a, clr_a, req_b, clr_b, req_c, clr_c;
  logic       se_a, se_b, se_c;
  logic [8:0] seg_a, seg_b, seg_c;
  logic [2:0] val_a, val_b, val_c;
  logic       busy_a, busy_b, busy_c;
  logic       done_a, done_b, done_c;

  nine_segment_dice_controller #(
    .SCAN_DIV(4), .ROLL_STEP_BASE(2), .ROLL_STEPS(4), .MAX_FACE(6)
  ) dut_a (
    .clk(clk), .rst(rst), .roll_req(req_a), .clear(clr_a), .scan_enable(se_a),
    .segments(seg_a), .value(val_a), .busy(busy_a), .done(done_a)
  );

  nine_segment_dice_controller #(
    .SCAN_DIV(4), .ROLL_STEP_BASE(2), .ROLL_STEPS(1), .MAX_FACE(7)
  ) dut_b (
    .clk(clk), .rst(rst), .roll_req(req_b), .clear(clr_b), .scan_enable(se_b),
    .segments(seg_b), .value(val_b), .busy(busy_b), .done(done_b)
  );

  nine_segment_dice_controller #(
    .SCAN_DIV(4), .ROLL_STEP_BASE(2), .ROLL_STEPS(3), .MAX_FACE(7)
  ) dut_c (
    .clk(clk), .rst(rst), .roll_req(req_c), .clear(clr_c), .scan_enable(se_c),
    .segments(seg_c), .value(val_c), .busy(busy_c), .done(done_c)
  );

  int cyc;
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         cyc;
    int         dut;
    logic [2:0] v;
    logic [8:0] s;
    logic       b;
    logic       d;
  } exp_t;

  exp_t sb[$];

  task automatic push_run(input int dut, input int c0, input int n, input logic [2:0] v,
                          input logic [8:0] s, input logic b, input logic d);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.cyc = c0 + i;
      e.dut = dut;
      e.v   = v;
      e.s   = s;
      e.b   = b;
      e.d   = d;
      sb.push_back(e);
    end
  endtask

  task automatic goto(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: scan cadence on every cycle, plus any queued expectation due now.
  always @(negedge clk) begin
    logic [2:0] ov;
    logic [8:0] os;
    logic       ob, od, ose;
    if (!rst) begin
      for (int d = 0; d < 3; d++) begin
        ose = (d == 0) ? se_a : (d == 1) ? se_b : se_c;
        total++;
        if (ose !== ((cyc % 4) == 3)) begin
          bad++;
          $display("FAIL scan dut%0d cyc=%0d got=%b want=%b", d, cyc, ose, ((cyc % 4) == 3));
        end
      end
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc <= cyc) begin
          case (sb[i].dut)
            0:       begin ov = val_a; os = seg_a; ob = busy_a; od = done_a; end
            1:       begin ov = val_b; os = seg_b; ob = busy_b; od = done_b; end
            default: begin ov = val_c; os = seg_c; ob = busy_c; od = done_c; end
          endcase
          total++;
          if (sb[i].cyc < cyc) begin
            bad++;
            $display("FAIL missed dut%0d cyc=%0d expectation not checked", sb[i].dut, sb[i].cyc);
          end else if ({ov, os, ob, od} !== {sb[i].v, sb[i].s, sb[i].b, sb[i].d}) begin
            bad++;
            $display("FAIL outputs dut%0d cyc=%0d got v=%0d seg=%b busy=%b done=%b want v=%0d seg=%b busy=%b done=%b",
                     sb[i].dut, cyc, ov, os, ob, od, sb[i].v, sb[i].s, sb[i].b, sb[i].d);
          end
          sb.delete(i);
        end
      end
    end
  end

  initial begin
    rst   = 1'b1;
    req_a = 1'b0; clr_a = 1'b0;
    req_b = 1'b0; clr_b = 1'b0;
    req_c = 1'b0; clr_c = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state, cycles 0..2
    for (int d = 0; d < 3; d++) push_run(d, 0, 3, 3'd0, 9'b000000000, 1'b0, 1'b0);

    // Full roll on A, seed 4 at cycle 3
    goto(3);
    req_a = 1'b1;
    push_run(0,  4, 2, 3'd4, 9'b101000101, 1'b1, 1'b0);
    push_run(0,  6, 4, 3'd5, 9'b101010101, 1'b1, 1'b0);
    push_run(0, 10, 6, 3'd6, 9'b111000111, 1'b1, 1'b0);
    push_run(0, 16, 8, 3'd1, 9'b000010000, 1'b1, 1'b0);
    push_run(0, 24, 1, 3'd1, 9'b000010000, 1'b0, 1'b1);
    push_run(0, 25, 6, 3'd1, 9'b000010000, 1'b0, 1'b0);

    // C: MAX_FACE=7, 3 steps, seed 6 at cycle 5 -> faces 6,7,1
    goto(5);
    req_a = 1'b0;
    req_c = 1'b1;
    push_run(2,  6, 2, 3'd6, 9'b111000111, 1'b1, 1'b0);
    push_run(2,  8, 4, 3'd7, 9'b111010111, 1'b1, 1'b0);
    push_run(2, 12, 6, 3'd1, 9'b000010000, 1'b1, 1'b0);
    push_run(2, 18, 1, 3'd1, 9'b000010000, 1'b0, 1'b1);
    push_run(2, 19, 7, 3'd1, 9'b000010000, 1'b0, 1'b0);

    // B: MAX_FACE=7, 1 step, seed 7 at cycle 6
    goto(6);
    req_b = 1'b1;
    push_run(1,  7,  2, 3'd7, 9'b111010111, 1'b1, 1'b0);
    push_run(1,  9,  1, 3'd7, 9'b111010111, 1'b0, 1'b1);
    push_run(1, 10, 11, 3'd7, 9'b111010111, 1'b0, 1'b0);

    goto(7);
    req_c = 1'b0;

    // Edge while A is rolling must be ignored
    goto(8);
    req_a = 1'b1;
    req_b = 1'b0;
    goto(10);
    req_a = 1'b0;

    // Re-roll from SHOW on A, seed 1 at cycle 30, with another mid-roll pulse
    goto(30);
    req_a = 1'b1;
    push_run(0, 31, 2, 3'd1, 9'b000010000, 1'b1, 1'b0);
    push_run(0, 33, 4, 3'd2, 9'b100000001, 1'b1, 1'b0);
    push_run(0, 37, 6, 3'd3, 9'b100010001, 1'b1, 1'b0);
    push_run(0, 43, 8, 3'd4, 9'b101000101, 1'b1, 1'b0);
    push_run(0, 51, 1, 3'd4, 9'b101000101, 1'b0, 1'b1);
    push_run(0, 52, 6, 3'd4, 9'b101000101, 1'b0, 1'b0);
    goto(32);
    req_a = 1'b0;
    goto(38);
    req_a = 1'b1;
    goto(40);
    req_a = 1'b0;

    // Third roll on A, aborted by clear coinciding with an edge at cycle 64
    goto(58);
    push_run(0, 58, 3, 3'd4, 9'b101000101, 1'b0, 1'b0);
    goto(60);
    req_a = 1'b1;
    push_run(0, 61, 2, 3'd1, 9'b000010000, 1'b1, 1'b0);
    push_run(0, 63, 2, 3'd2, 9'b100000001, 1'b1, 1'b0);
    goto(62);
    req_a = 1'b0;
    goto(64);
    req_a = 1'b1;
    clr_a = 1'b1;
    push_run(0, 65, 26, 3'd0, 9'b000000000, 1'b0, 1'b0);
    goto(65);
    clr_a = 1'b0;
    goto(66);
    req_a = 1'b0;

    goto(92);
    @(negedge clk);
    #1;
    while (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL leftover dut%0d cyc=%0d expectation never reached", sb[0].dut, sb[0].cyc);
      sb.delete(0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
